// File: rtl/threshold_event_pkg.sv
// threshold_event_pkg: shared types and constants for the threshold event detector
package threshold_event_pkg;
  localparam int STAMP_W = 16;
  localparam logic EVT_RISE = 1'b1;
  localparam logic EVT_FALL = 1'b0;
  typedef enum logic [1:0] {LOW, RISE_PEND, HIGH, FALL_PEND} state_t;
  typedef struct packed {
    logic typ;
    logic [STAMP_W-1:0] stamp;
  } evt_t;
endpackage

// File: rtl/event_fifo.sv
// event_fifo: synchronous FIFO with full/empty flags and same-cycle push/pop
module event_fifo #(
  parameter int W = 17,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  logic do_push, do_pop;
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd[AW-1:0]];
  // storage and pointers; a pop frees the slot a simultaneous push needs when full
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr[AW-1:0]] <= din;
        wr <= wr + 1'b1;
      end
      if (do_pop) rd <= rd + 1'b1;
    end
endmodule

// File: rtl/threshold_event_detector.sv
// threshold_event_detector: hysteresis crossing detector with hold qualification and timestamped event FIFO
module threshold_event_detector
  import threshold_event_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int HOLD = 3,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   thresh_hi,
  input  logic [WIDTH-1:0]   thresh_lo,
  output logic               level,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic               evt_type,
  output logic [STAMP_W-1:0] evt_stamp,
  output logic               overflow,
  input  logic               clr_overflow
);
  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD);
  state_t state;
  logic [CW-1:0] cnt;
  logic [STAMP_W-1:0] idx;
  logic rq, fq, rise_done, fall_done, push, pop, full, empty;
  evt_t head, evt;
  assign rq = data_in >= thresh_hi;
  assign fq = data_in < thresh_lo;
  assign rise_done = in_valid && rq && ((state == LOW && HOLD == 1) || (state == RISE_PEND && cnt + 1'b1 == HOLD_C));
  assign fall_done = in_valid && fq && ((state == HIGH && HOLD == 1) || (state == FALL_PEND && cnt + 1'b1 == HOLD_C));
  assign push = rise_done || fall_done;
  assign pop = evt_valid && evt_ready;
  assign evt = '{typ: rise_done ? EVT_RISE : EVT_FALL, stamp: idx};
  assign evt_valid = !empty;
  assign evt_type = head.typ;
  assign evt_stamp = head.stamp;
  // crossing FSM with run counter, sample index and registered level
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= LOW;
      cnt <= '0;
      idx <= '0;
      level <= 1'b0;
    end else if (in_valid) begin
      idx <= idx + 1'b1;
      case (state)
        LOW: if (rq) begin
          state <= HOLD == 1 ? HIGH : RISE_PEND;
          cnt <= HOLD == 1 ? '0 : CW'(1);
          level <= HOLD == 1;
        end
        RISE_PEND: if (!rq) begin
          state <= LOW;
          cnt <= '0;
        end else if (rise_done) begin
          state <= HIGH;
          cnt <= '0;
          level <= 1'b1;
        end else cnt <= cnt + 1'b1;
        HIGH: if (fq) begin
          state <= HOLD == 1 ? LOW : FALL_PEND;
          cnt <= HOLD == 1 ? '0 : CW'(1);
          level <= HOLD != 1;
        end
        FALL_PEND: if (!fq) begin
          state <= HIGH;
          cnt <= '0;
        end else if (fall_done) begin
          state <= LOW;
          cnt <= '0;
          level <= 1'b0;
        end else cnt <= cnt + 1'b1;
        default: state <= LOW;
      endcase
    end
  // sticky overflow: a dropped event wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst)
    if (rst) overflow <= 1'b0;
    else if (push && full && !pop) overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  event_fifo #(.W($bits(evt_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(evt),
    .dout(head),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_threshold_event_detector.sv
// tb_threshold_event_detector: directed scenario tests for threshold_event_detector
module tb_threshold_event_detector;
  logic clk = 0, rst = 1, in_valid = 0, evt_ready = 0, clr_overflow = 0;
  logic [15:0] data_in = 0, thresh_hi = 16'd1000, thresh_lo = 16'd800;
  logic level, evt_valid, evt_type, overflow;
  logic [15:0] evt_stamp;
  int checks = 0, failures = 0;

  threshold_event_detector #(.WIDTH(16), .HOLD(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
    .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .level(level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
    .evt_stamp(evt_stamp), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [15:0] d, input logic v);
    data_in = d;
    in_valid = v;
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    evt_ready = 0;
    clr_overflow = 0;
    in_valid = 0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) step(16'd1200, 1);
    checks++; if (level !== 1'b1) begin failures++; $display("FAIL reset_pre_level got=%0b exp=1", level); end
    checks++; if (evt_valid !== 1'b1) begin failures++; $display("FAIL reset_pre_valid got=%0b exp=1", evt_valid); end
    #2 rst = 1;
    #1;
    checks++; if (level !== 1'b0) begin failures++; $display("FAIL reset_level got=%0b exp=0", level); end
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", evt_valid); end
    checks++; if (evt_type !== 1'b0 || evt_stamp !== 16'd0) begin failures++; $display("FAIL reset_head got=%0b/%0h exp=0/0", evt_type, evt_stamp); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    @(posedge clk);
    #1 rst = 0;
    step(16'd900, 0);
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL reset_empty_after got=%0b exp=0", evt_valid); end
  endtask

  task automatic test_clean_rise();
    do_reset();
    step(16'd500, 1);
    step(16'd1200, 1);
    step(16'd1200, 1);
    checks++; if (level !== 1'b0 || evt_valid !== 1'b0) begin failures++; $display("FAIL rise_early got=%0b/%0b exp=0/0", level, evt_valid); end
    step(16'd1200, 1);
    checks++; if (level !== 1'b1) begin failures++; $display("FAIL rise_level got=%0b exp=1", level); end
    checks++; if (evt_valid !== 1'b1) begin failures++; $display("FAIL rise_valid got=%0b exp=1", evt_valid); end
    checks++; if (evt_type !== 1'b1 || evt_stamp !== 16'd3) begin failures++; $display("FAIL rise_event got=%0b/%0d exp=1/3", evt_type, evt_stamp); end
    step(16'd1200, 0);
    checks++; if (evt_stamp !== 16'd3) begin failures++; $display("FAIL rise_hold_stable got=%0d exp=3", evt_stamp); end
    evt_ready = 1;
    step(16'd1200, 0);
    evt_ready = 0;
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL rise_drain got=%0b exp=0", evt_valid); end
  endtask

  task automatic test_glitch();
    do_reset();
    step(16'd1200, 1);
    step(16'd1200, 1);
    step(16'd900, 1);
    step(16'd1200, 1);
    step(16'd1200, 1);
    checks++; if (level !== 1'b0 || evt_valid !== 1'b0) begin failures++; $display("FAIL glitch_reject got=%0b/%0b exp=0/0", level, evt_valid); end
    step(16'd1200, 1);
    checks++; if (level !== 1'b1 || evt_valid !== 1'b1) begin failures++; $display("FAIL glitch_rise got=%0b/%0b exp=1/1", level, evt_valid); end
    checks++; if (evt_type !== 1'b1 || evt_stamp !== 16'd5) begin failures++; $display("FAIL glitch_event got=%0b/%0d exp=1/5", evt_type, evt_stamp); end
  endtask

  task automatic test_hysteresis();
    evt_ready = 1;
    step(16'd900, 0);
    evt_ready = 0;
    repeat (5) step(16'd900, 1);
    checks++; if (level !== 1'b1 || evt_valid !== 1'b0) begin failures++; $display("FAIL hyst_band got=%0b/%0b exp=1/0", level, evt_valid); end
    step(16'd700, 1);
    step(16'd700, 1);
    checks++; if (level !== 1'b1 || evt_valid !== 1'b0) begin failures++; $display("FAIL hyst_pending got=%0b/%0b exp=1/0", level, evt_valid); end
    step(16'd700, 1);
    checks++; if (level !== 1'b0 || evt_valid !== 1'b1) begin failures++; $display("FAIL hyst_fall got=%0b/%0b exp=0/1", level, evt_valid); end
    checks++; if (evt_type !== 1'b0 || evt_stamp !== 16'd13) begin failures++; $display("FAIL hyst_event got=%0b/%0d exp=0/13", evt_type, evt_stamp); end
  endtask

  task automatic test_overflow();
    logic exp_t [8];
    logic [15:0] exp_s [8];
    exp_t = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_s = '{16'd2, 16'd5, 16'd8, 16'd11, 16'd20, 16'd23, 16'd26, 16'd29};
    do_reset();
    for (int e = 0; e < 5; e++) repeat (3) step(e % 2 == 0 ? 16'd1200 : 16'd700, 1);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", overflow); end
    evt_ready = 1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (evt_valid !== 1'b1 || evt_type !== exp_t[k] || evt_stamp !== exp_s[k]) begin failures++; $display("FAIL ovf_drain%0d got=%0b/%0b/%0d exp=1/%0b/%0d", k, evt_valid, evt_type, evt_stamp, exp_t[k], exp_s[k]); end
      step(16'd900, 0);
    end
    evt_ready = 0;
    checks++; if (evt_valid !== 1'b0 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_after_drain got=%0b/%0b exp=0/1", evt_valid, overflow); end
    clr_overflow = 1;
    step(16'd900, 0);
    clr_overflow = 0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
    for (int e = 0; e < 4; e++) repeat (3) step(e % 2 == 0 ? 16'd700 : 16'd1200, 1);
    checks++; if (overflow !== 1'b0 || evt_stamp !== 16'd17) begin failures++; $display("FAIL ovf_refill got=%0b/%0d exp=0/17", overflow, evt_stamp); end
    step(16'd700, 1);
    step(16'd700, 1);
    evt_ready = 1;
    step(16'd700, 1);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_pushpop got=%0b exp=0", overflow); end
    for (int k = 4; k < 8; k++) begin
      checks++; if (evt_valid !== 1'b1 || evt_type !== exp_t[k] || evt_stamp !== exp_s[k]) begin failures++; $display("FAIL ovf_pp_drain%0d got=%0b/%0b/%0d exp=1/%0b/%0d", k, evt_valid, evt_type, evt_stamp, exp_t[k], exp_s[k]); end
      step(16'd900, 0);
    end
    evt_ready = 0;
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL ovf_pp_empty got=%0b exp=0", evt_valid); end
  endtask

  task automatic test_gaps_wrap();
    do_reset();
    step(16'd1200, 1);
    step(16'd1200, 0);
    step(16'd1200, 1);
    step(16'd500, 0);
    checks++; if (evt_valid !== 1'b0 || level !== 1'b0) begin failures++; $display("FAIL gap_pending got=%0b/%0b exp=0/0", evt_valid, level); end
    step(16'd1200, 1);
    checks++; if (evt_valid !== 1'b1 || level !== 1'b1 || evt_stamp !== 16'd2) begin failures++; $display("FAIL gap_rise got=%0b/%0b/%0d exp=1/1/2", evt_valid, level, evt_stamp); end
    do_reset();
    repeat (16'hFFFD) step(16'd900, 1);
    repeat (3) step(16'd1200, 1);
    checks++; if (evt_valid !== 1'b1 || evt_type !== 1'b1 || evt_stamp !== 16'hFFFF) begin failures++; $display("FAIL wrap_ffff got=%0b/%0b/%0h exp=1/1/ffff", evt_valid, evt_type, evt_stamp); end
    repeat (3) step(16'd700, 1);
    evt_ready = 1;
    step(16'd900, 0);
    evt_ready = 0;
    checks++; if (evt_valid !== 1'b1 || evt_type !== 1'b0 || evt_stamp !== 16'h0002) begin failures++; $display("FAIL wrap_0002 got=%0b/%0b/%0h exp=1/0/0002", evt_valid, evt_type, evt_stamp); end
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_glitch();
    test_hysteresis();
    test_overflow();
    test_gaps_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
